// File: rtl/ysyx_23060203_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060203_pkg
// Purpose  : Shared core package for the memory read arbiter: AXI field
//            widths, master index constants and the arbiter FSM state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060203_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  // Master indices; also the encoding of the arbiter grant bit.
  localparam logic ARB_IFU = 1'b0;
  localparam logic ARB_LSU = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR0  = 3'd1,
    R0   = 3'd2,
    AR1  = 3'd3,
    R1   = 3'd4
  } arb_state_t;

  // True while the LSU owns the read port.
  function automatic logic owner_is_lsu(arb_state_t s);
    return (s == AR1) || (s == R1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060203_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_if
// Purpose  : AXI4 bundle (AW/W/B/AR/R) used between the core masters, the
//            read arbiter and the SoC side.
// Modports : in  - seen from the block that receives requests (slave side)
//            out - seen from the block that issues requests (master side)
// Revision : 1.0 - initial release
// ============================================================================
interface axi_if;
  import ysyx_23060203_pkg::*;

  // Write address
  logic [AXI_ID_W-1:0]   awid;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [AXI_LEN_W-1:0]  awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  // Write data
  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  // Write response
  logic [AXI_ID_W-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  // Read address
  logic [AXI_ID_W-1:0]   arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_LEN_W-1:0]  arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  // Read data
  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport in (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport out (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface
`default_nettype wire

// File: rtl/ysyx_23060203_mem_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060203_arb_pick
// Purpose  : Combinational winner select for the two-master read arbiter.
//            YSYX_23060203_ARB_RR_EN defined   : round-robin on a tie,
//                                                 loser of the last grant wins.
//            YSYX_23060203_ARB_RR_EN undefined : fixed priority, LSU over IFU.
// Ports    : req0  in  1  IFU read request
//            req1  in  1  LSU read request
//            last  in  1  winner of the previous grant (ARB_IFU/ARB_LSU)
//            grant out 1  winner (ARB_IFU/ARB_LSU); only meaningful if a req
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060203_arb_pick
  import ysyx_23060203_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

`ifdef YSYX_23060203_ARB_RR_EN
  always_comb begin
    grant = ARB_IFU;
    if (req0 && req1) begin
      grant = ~last;
    end else if (req1) begin
      grant = ARB_LSU;
    end
  end
`else
  assign grant = req1 ? ARB_LSU : ARB_IFU;

  logic unused_last;
  assign unused_last = last;
  logic unused_req0;
  assign unused_req0 = req0;
`endif

endmodule
`default_nettype wire

// File: rtl/ysyx_23060203_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060203_mem_arbiter
// Purpose  : Shares the single downstream AXI4 read port between the IFU and
//            the LSU, one transaction at a time; the granted master owns AR
//            and R until its last beat. LSU writes pass straight through.
//            Build option YSYX_23060203_ARB_RR_EN selects round-robin tie
//            breaking instead of fixed LSU priority.
// Ports    : clock  in       system clock
//            reset  in       synchronous, active-high
//            ifu_r  axi_if.in   IFU read requester (AR/R)
//            lsu_r  axi_if.in   LSU read requester (AR/R)
//            lsu_w  axi_if.in   LSU write requester (AW/W/B)
//            mem_r  axi_if.out  shared downstream read port
//            mem_w  axi_if.out  downstream write port (pass-through of lsu_w)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060203_mem_arbiter
  import ysyx_23060203_pkg::*;
(
  input  logic clock,
  input  logic reset,
  axi_if.in    ifu_r,
  axi_if.in    lsu_r,
  axi_if.in    lsu_w,
  axi_if.out   mem_r,
  axi_if.out   mem_w
);

  arb_state_t state;
  arb_state_t state_next;
  logic       grant;
  logic       last_winner;
  logic       any_req;
  logic       owner_lsu;

  assign any_req   = ifu_r.arvalid || lsu_r.arvalid;
  assign owner_lsu = owner_is_lsu(state);

  ysyx_23060203_arb_pick u_pick (
    .req0  (ifu_r.arvalid),
    .req1  (lsu_r.arvalid),
    .last  (last_winner),
    .grant (grant)
  );

`ifdef YSYX_23060203_ARB_RR_EN
  // Remembers who won the most recent IDLE -> ARx grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_winner <= ARB_IFU;
    end else if ((state == IDLE) && any_req) begin
      last_winner <= grant;
    end
  end
`else
  assign last_winner = ARB_IFU;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. The owner's own arvalid/rready stand in for the
  // forwarded mem_r copies, which are identical while it owns the port.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (any_req) state_next = (grant == ARB_LSU) ? AR1 : AR0;
      AR0:  if (ifu_r.arvalid && mem_r.arready) state_next = R0;
      R0:   if (mem_r.rvalid && ifu_r.rready && mem_r.rlast) state_next = IDLE;
      AR1:  if (lsu_r.arvalid && mem_r.arready) state_next = R1;
      R1:   if (mem_r.rvalid && lsu_r.rready && mem_r.rlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Handshake signals are gated by ownership; AR payload
  // follows the IFU whenever the LSU is not the owner, so the bus never
  // floats to X in IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_r.arid    = owner_lsu ? lsu_r.arid    : ifu_r.arid;
    mem_r.araddr  = owner_lsu ? lsu_r.araddr  : ifu_r.araddr;
    mem_r.arlen   = owner_lsu ? lsu_r.arlen   : ifu_r.arlen;
    mem_r.arsize  = owner_lsu ? lsu_r.arsize  : ifu_r.arsize;
    mem_r.arburst = owner_lsu ? lsu_r.arburst : ifu_r.arburst;
    mem_r.arvalid = 1'b0;
    mem_r.rready  = 1'b0;
    ifu_r.arready = 1'b0;
    lsu_r.arready = 1'b0;
    ifu_r.rvalid  = 1'b0;
    lsu_r.rvalid  = 1'b0;
    case (state)
      AR0: begin
        mem_r.arvalid = ifu_r.arvalid;
        ifu_r.arready = mem_r.arready;
      end
      R0: begin
        ifu_r.rvalid = mem_r.rvalid;
        mem_r.rready = ifu_r.rready;
      end
      AR1: begin
        mem_r.arvalid = lsu_r.arvalid;
        lsu_r.arready = mem_r.arready;
      end
      R1: begin
        lsu_r.rvalid = mem_r.rvalid;
        mem_r.rready = lsu_r.rready;
      end
      default: ;
    endcase
  end

  // R payload is broadcast; only the owner sees rvalid, so the copy to the
  // other master is inert.
  assign ifu_r.rid   = mem_r.rid;
  assign ifu_r.rdata = mem_r.rdata;
  assign ifu_r.rresp = mem_r.rresp;
  assign ifu_r.rlast = mem_r.rlast;
  assign lsu_r.rid   = mem_r.rid;
  assign lsu_r.rdata = mem_r.rdata;
  assign lsu_r.rresp = mem_r.rresp;
  assign lsu_r.rlast = mem_r.rlast;

  // --------------------------------------------------------------------------
  // Write path: straight wires, no interaction with the read FSM.
  // --------------------------------------------------------------------------
  assign mem_w.awid    = lsu_w.awid;
  assign mem_w.awaddr  = lsu_w.awaddr;
  assign mem_w.awlen   = lsu_w.awlen;
  assign mem_w.awsize  = lsu_w.awsize;
  assign mem_w.awburst = lsu_w.awburst;
  assign mem_w.awvalid = lsu_w.awvalid;
  assign lsu_w.awready = mem_w.awready;
  assign mem_w.wdata   = lsu_w.wdata;
  assign mem_w.wstrb   = lsu_w.wstrb;
  assign mem_w.wlast   = lsu_w.wlast;
  assign mem_w.wvalid  = lsu_w.wvalid;
  assign lsu_w.wready  = mem_w.wready;
  assign lsu_w.bid     = mem_w.bid;
  assign lsu_w.bresp   = mem_w.bresp;
  assign lsu_w.bvalid  = mem_w.bvalid;
  assign mem_w.bready  = lsu_w.bready;

  // --------------------------------------------------------------------------
  // Channels each port does not carry are tied off.
  // --------------------------------------------------------------------------
  assign ifu_r.awready = 1'b0;
  assign ifu_r.wready  = 1'b0;
  assign ifu_r.bid     = '0;
  assign ifu_r.bresp   = '0;
  assign ifu_r.bvalid  = 1'b0;
  assign lsu_r.awready = 1'b0;
  assign lsu_r.wready  = 1'b0;
  assign lsu_r.bid     = '0;
  assign lsu_r.bresp   = '0;
  assign lsu_r.bvalid  = 1'b0;
  assign lsu_w.arready = 1'b0;
  assign lsu_w.rid     = '0;
  assign lsu_w.rdata   = '0;
  assign lsu_w.rresp   = '0;
  assign lsu_w.rlast   = 1'b0;
  assign lsu_w.rvalid  = 1'b0;

  assign mem_r.awid    = '0;
  assign mem_r.awaddr  = '0;
  assign mem_r.awlen   = '0;
  assign mem_r.awsize  = '0;
  assign mem_r.awburst = '0;
  assign mem_r.awvalid = 1'b0;
  assign mem_r.wdata   = '0;
  assign mem_r.wstrb   = '0;
  assign mem_r.wlast   = 1'b0;
  assign mem_r.wvalid  = 1'b0;
  assign mem_r.bready  = 1'b0;
  assign mem_w.arid    = '0;
  assign mem_w.araddr  = '0;
  assign mem_w.arlen   = '0;
  assign mem_w.arsize  = '0;
  assign mem_w.arburst = '0;
  assign mem_w.arvalid = 1'b0;
  assign mem_w.rready  = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{
    ifu_r.awid, ifu_r.awaddr, ifu_r.awlen, ifu_r.awsize, ifu_r.awburst,
    ifu_r.awvalid, ifu_r.wdata, ifu_r.wstrb, ifu_r.wlast, ifu_r.wvalid,
    ifu_r.bready,
    lsu_r.awid, lsu_r.awaddr, lsu_r.awlen, lsu_r.awsize, lsu_r.awburst,
    lsu_r.awvalid, lsu_r.wdata, lsu_r.wstrb, lsu_r.wlast, lsu_r.wvalid,
    lsu_r.bready,
    lsu_w.arid, lsu_w.araddr, lsu_w.arlen, lsu_w.arsize, lsu_w.arburst,
    lsu_w.arvalid, lsu_w.rready,
    mem_r.awready, mem_r.wready, mem_r.bid, mem_r.bresp, mem_r.bvalid,
    mem_w.arready, mem_w.rid, mem_w.rdata, mem_w.rresp, mem_w.rlast,
    mem_w.rvalid
  };

`ifndef SYNTHESIS
  // --------------------------------------------------------------------------
  // Contention counters: cycles a master waits while the other owns the port.
  // --------------------------------------------------------------------------
  logic [31:0] ifu_wait_cycles;
  logic [31:0] lsu_wait_cycles;

  always_ff @(posedge clock) begin
    if (reset) begin
      ifu_wait_cycles <= '0;
      lsu_wait_cycles <= '0;
    end else begin
      if (ifu_r.arvalid && owner_lsu) begin
        ifu_wait_cycles <= ifu_wait_cycles + 32'd1;
      end
      if (lsu_r.arvalid && ((state == AR0) || (state == R0))) begin
        lsu_wait_cycles <= lsu_wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060203_mem_arbiter
// Purpose  : Self-checking bench for the two-master read arbiter. A table of
//            per-cycle vectors covers single reads, a fixed tie, and
//            backpressure; hand-written sequences cover repeated ties
//            (result depends on YSYX_23060203_ARB_RR_EN), write isolation and
//            reset in the middle of a read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060203_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_if ifu_r ();
  axi_if lsu_r ();
  axi_if lsu_w ();
  axi_if mem_r ();
  axi_if mem_w ();

  ysyx_23060203_mem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .ifu_r (ifu_r),
    .lsu_r (lsu_r),
    .lsu_w (lsu_w),
    .mem_r (mem_r),
    .mem_w (mem_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ins   = {ifu arvalid, lsu arvalid, mem arready, mem rvalid, mem rlast,
  //          ifu rready, lsu rready}
  // eflag = {mem arvalid, ifu arready, lsu arready, ifu rvalid, lsu rvalid,
  //          mem rready}
  typedef struct {
    string       nm;
    logic [6:0]  ins;
    logic [31:0] iaddr;
    logic [31:0] laddr;
    logic [31:0] rdata;
    logic [5:0]  eflags;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string nm, logic [6:0] ins, logic [31:0] ia,
                              logic [31:0] la, logic [31:0] rd,
                              logic [5:0] ef, logic [31:0] ea);
    vec_t v;
    v.nm = nm; v.ins = ins; v.iaddr = ia; v.laddr = la; v.rdata = rd;
    v.eflags = ef; v.eaddr = ea;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [5:0] got_flags();
    return {mem_r.arvalid, ifu_r.arready, lsu_r.arready,
            ifu_r.rvalid, lsu_r.rvalid, mem_r.rready};
  endfunction

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    ifu_r.awid = '0; ifu_r.awaddr = '0; ifu_r.awlen = '0; ifu_r.awsize = '0;
    ifu_r.awburst = '0; ifu_r.awvalid = 1'b0; ifu_r.wdata = '0;
    ifu_r.wstrb = '0; ifu_r.wlast = 1'b0; ifu_r.wvalid = 1'b0;
    ifu_r.bready = 1'b0; ifu_r.arid = 4'h1; ifu_r.araddr = '0;
    ifu_r.arlen = '0; ifu_r.arsize = 3'd2; ifu_r.arburst = 2'b01;
    ifu_r.arvalid = 1'b0; ifu_r.rready = 1'b0;
    lsu_r.awid = '0; lsu_r.awaddr = '0; lsu_r.awlen = '0; lsu_r.awsize = '0;
    lsu_r.awburst = '0; lsu_r.awvalid = 1'b0; lsu_r.wdata = '0;
    lsu_r.wstrb = '0; lsu_r.wlast = 1'b0; lsu_r.wvalid = 1'b0;
    lsu_r.bready = 1'b0; lsu_r.arid = 4'h2; lsu_r.araddr = '0;
    lsu_r.arlen = '0; lsu_r.arsize = 3'd2; lsu_r.arburst = 2'b01;
    lsu_r.arvalid = 1'b0; lsu_r.rready = 1'b0;
    lsu_w.awid = '0; lsu_w.awaddr = '0; lsu_w.awlen = '0; lsu_w.awsize = '0;
    lsu_w.awburst = '0; lsu_w.awvalid = 1'b0; lsu_w.wdata = '0;
    lsu_w.wstrb = '0; lsu_w.wlast = 1'b0; lsu_w.wvalid = 1'b0;
    lsu_w.bready = 1'b0; lsu_w.arid = '0; lsu_w.araddr = '0;
    lsu_w.arlen = '0; lsu_w.arsize = '0; lsu_w.arburst = '0;
    lsu_w.arvalid = 1'b0; lsu_w.rready = 1'b0;
    mem_r.awready = 1'b0; mem_r.wready = 1'b0; mem_r.bid = '0;
    mem_r.bresp = '0; mem_r.bvalid = 1'b0; mem_r.arready = 1'b0;
    mem_r.rid = '0; mem_r.rdata = '0; mem_r.rresp = '0; mem_r.rlast = 1'b0;
    mem_r.rvalid = 1'b0;
    mem_w.awready = 1'b0; mem_w.wready = 1'b0; mem_w.bid = '0;
    mem_w.bresp = '0; mem_w.bvalid = 1'b0; mem_w.arready = 1'b0;
    mem_w.rid = '0; mem_w.rdata = '0; mem_w.rresp = '0; mem_w.rlast = 1'b0;
    mem_w.rvalid = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    {ifu_r.arvalid, lsu_r.arvalid, mem_r.arready, mem_r.rvalid, mem_r.rlast,
     ifu_r.rready, lsu_r.rready} = v.ins;
    ifu_r.araddr = v.iaddr;
    lsu_r.araddr = v.laddr;
    mem_r.rdata  = v.rdata;
    #1;
    check({v.nm, "_flags"}, got_flags(), v.eflags);
    check({v.nm, "_araddr"}, mem_r.araddr, v.eaddr);
    if (v.eflags[2]) check({v.nm, "_ifu_rdata"}, ifu_r.rdata, v.rdata);
    if (v.eflags[1]) check({v.nm, "_lsu_rdata"}, lsu_r.rdata, v.rdata);
    step();
  endtask

  initial begin
    int          d_start;
    logic [31:0] ifu_w0, lsu_w0;
    logic [2:0]  win;

    // ---------------- vector table ----------------
    // IFU-only read
    vq.push_back(mk("a_idle",  7'b0000000, 32'h8000_0000, 0, 0, 6'b000000, 32'h8000_0000));
    vq.push_back(mk("a_req",   7'b1000000, 32'h8000_0000, 0, 0, 6'b000000, 32'h8000_0000));
    vq.push_back(mk("a_ar",    7'b1010000, 32'h8000_0000, 0, 0, 6'b110000, 32'h8000_0000));
    vq.push_back(mk("a_rwait", 7'b0000010, 32'h8000_0000, 0, 0, 6'b000001, 32'h8000_0000));
    vq.push_back(mk("a_rbeat", 7'b0001110, 32'h8000_0000, 0, 32'h0000_0013, 6'b000101, 32'h8000_0000));
    vq.push_back(mk("a_done",  7'b0000000, 32'h8000_0000, 0, 0, 6'b000000, 32'h8000_0000));
    // Tie: LSU first, IFU after one idle bubble
    vq.push_back(mk("b_tie",      7'b1100000, 32'h8000_0004, 32'h8000_1000, 0, 6'b000000, 32'h8000_0004));
    vq.push_back(mk("b_ar_wait",  7'b1100000, 32'h8000_0004, 32'h8000_1000, 0, 6'b100000, 32'h8000_1000));
    vq.push_back(mk("b_ar",       7'b1110000, 32'h8000_0004, 32'h8000_1000, 0, 6'b101000, 32'h8000_1000));
    vq.push_back(mk("b_beat0",    7'b1001001, 32'h8000_0004, 32'h8000_1000, 32'haaaa_0001, 6'b000011, 32'h8000_1000));
    vq.push_back(mk("b_beat1",    7'b1001101, 32'h8000_0004, 32'h8000_1000, 32'haaaa_0002, 6'b000011, 32'h8000_1000));
    vq.push_back(mk("b_bubble",   7'b1000000, 32'h8000_0004, 32'h8000_1000, 0, 6'b000000, 32'h8000_0004));
    vq.push_back(mk("b_ifu_ar",   7'b1010000, 32'h8000_0004, 32'h8000_1000, 0, 6'b110000, 32'h8000_0004));
    vq.push_back(mk("b_ifu_beat", 7'b0001110, 32'h8000_0004, 32'h8000_1000, 32'h0000_0093, 6'b000101, 32'h8000_0004));
    // Backpressure with the LSU waiting
    d_start = vq.size();
    vq.push_back(mk("d_req", 7'b1000000, 32'h8000_0040, 32'h8000_2000, 0, 6'b000000, 32'h8000_0040));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk("d_ar_stall", 7'b1100000, 32'h8000_0040, 32'h8000_2000, 0, 6'b100000, 32'h8000_0040));
    vq.push_back(mk("d_ar", 7'b1110000, 32'h8000_0040, 32'h8000_2000, 0, 6'b110000, 32'h8000_0040));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("d_r_stall", 7'b0101100, 32'h8000_0040, 32'h8000_2000, 32'h1234_5678, 6'b000100, 32'h8000_0040));
    vq.push_back(mk("d_r",       7'b0101110, 32'h8000_0040, 32'h8000_2000, 32'h1234_5678, 6'b000101, 32'h8000_0040));
    vq.push_back(mk("d_lsu_req", 7'b0100000, 32'h8000_0040, 32'h8000_2000, 0, 6'b000000, 32'h8000_0040));
    vq.push_back(mk("d_lsu_ar",  7'b0110000, 32'h8000_0040, 32'h8000_2000, 0, 6'b101000, 32'h8000_2000));
    vq.push_back(mk("d_lsu_r",   7'b0001101, 32'h8000_0040, 32'h8000_2000, 32'h5555_aaaa, 6'b000011, 32'h8000_2000));
    vq.push_back(mk("d_idle",    7'b0000000, 32'h8000_0040, 32'h8000_2000, 0, 6'b000000, 32'h8000_0040));

    // ---------------- reset values ----------------
    clear_inputs();
    @(negedge clock);
    ifu_r.arvalid = 1'b1; lsu_r.arvalid = 1'b1; mem_r.rvalid = 1'b1;
    mem_r.arready = 1'b1; ifu_r.rready = 1'b1; lsu_r.rready = 1'b1;
    step(); step();
    #1 check("reset_flags", got_flags(), 6'b000000);
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;

    // ---------------- table ----------------
    for (int k = 0; k < d_start; k++) apply(vq[k]);
    ifu_w0 = dut.ifu_wait_cycles;
    lsu_w0 = dut.lsu_wait_cycles;
    for (int k = d_start; k < vq.size(); k++) apply(vq[k]);
    check("d_lsu_wait_cnt", dut.lsu_wait_cycles - lsu_w0, 32'd10);
    check("d_ifu_wait_cnt", dut.ifu_wait_cycles - ifu_w0, 32'd0);

    // ---------------- three consecutive ties ----------------
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
`ifdef YSYX_23060203_ARB_RR_EN
    win = 3'b101;   // bit t: 1 = LSU wins tie t (LSU, IFU, LSU)
`else
    win = 3'b111;
`endif
    ifu_r.araddr = 32'h8000_0100; lsu_r.araddr = 32'h8000_0200;
    ifu_r.arvalid = 1'b1; lsu_r.arvalid = 1'b1;
    ifu_r.rready = 1'b1; lsu_r.rready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      mem_r.arready = 1'b0; mem_r.rvalid = 1'b0; mem_r.rlast = 1'b0;
      #1 check("c_idle_mav", mem_r.arvalid, 1'b0);
      step();
      mem_r.arready = 1'b1;
      #1;
      check("c_grant_addr", mem_r.araddr, win[t] ? 32'h8000_0200 : 32'h8000_0100);
      check("c_grant_arready", {ifu_r.arready, lsu_r.arready}, win[t] ? 2'b01 : 2'b10);
      step();
      mem_r.arready = 1'b0; mem_r.rvalid = 1'b1; mem_r.rlast = 1'b1;
      mem_r.rdata = 32'hc000_0000 + 32'(t);
      #1 check("c_rvalid", {ifu_r.rvalid, lsu_r.rvalid}, win[t] ? 2'b01 : 2'b10);
      step();
    end
    clear_inputs();
    step();

    // ---------------- write isolation during IFU read ----------------
    ifu_r.arvalid = 1'b1; ifu_r.araddr = 32'h8000_0300;
    step();
    mem_r.arready = 1'b1;
    step();
    ifu_r.arvalid = 1'b0; mem_r.arready = 1'b0;
    lsu_w.awaddr = 32'ha000_03f8; lsu_w.awvalid = 1'b1;
    lsu_w.wdata = 32'hdead_beef; lsu_w.wstrb = 4'b0001;
    lsu_w.wvalid = 1'b1; lsu_w.wlast = 1'b1; lsu_w.bready = 1'b1;
    mem_w.awready = 1'b1; mem_w.wready = 1'b1; mem_w.bvalid = 1'b1;
    mem_w.bid = 4'h3; mem_w.bresp = 2'b10;
    mem_r.rvalid = 1'b1; mem_r.rlast = 1'b1; mem_r.rdata = 32'h0000_0517;
    ifu_r.rready = 1'b1;
    #1;
    check("e_awaddr", mem_w.awaddr, 32'ha000_03f8);
    check("e_wstrb", mem_w.wstrb, 4'b0001);
    check("e_wdata", mem_w.wdata, 32'hdead_beef);
    check("e_w_valids", {mem_w.awvalid, mem_w.wvalid, mem_w.wlast, mem_w.bready}, 4'b1111);
    check("e_w_readys", {lsu_w.awready, lsu_w.wready, lsu_w.bvalid}, 3'b111);
    check("e_b_resp", {lsu_w.bid, lsu_w.bresp}, 6'b0011_10);
    check("e_ifu_r", {ifu_r.rvalid, ifu_r.rdata}, {1'b1, 32'h0000_0517});
    check("e_lsu_rvalid", lsu_r.rvalid, 1'b0);
    step();
    clear_inputs();
    step();

    // ---------------- reset in the middle of an LSU read ----------------
    lsu_r.arvalid = 1'b1; lsu_r.araddr = 32'h8000_0400;
    step();
    mem_r.arready = 1'b1;
    step();
    lsu_r.arvalid = 1'b0; mem_r.arready = 1'b0;
    mem_r.rvalid = 1'b1; mem_r.rlast = 1'b0; lsu_r.rready = 1'b1;
    #1 check("f_r1_rvalid", lsu_r.rvalid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 check("f_after_reset", got_flags(), 6'b000000);
    clear_inputs();
    ifu_r.arvalid = 1'b1; ifu_r.araddr = 32'h8000_0500;
    #1 check("f_idle_mav", mem_r.arvalid, 1'b0);
    step();
    mem_r.arready = 1'b1;
    #1;
    check("f_ifu_ar", got_flags(), 6'b110000);
    check("f_ifu_addr", mem_r.araddr, 32'h8000_0500);
    step();
    ifu_r.arvalid = 1'b0; mem_r.arready = 1'b0;
    mem_r.rvalid = 1'b1; mem_r.rlast = 1'b1; mem_r.rdata = 32'h0000_0055;
    ifu_r.rready = 1'b1;
    #1 check("f_ifu_r", got_flags(), 6'b000101);
    step();
    clear_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
